// File: rtl/bp_cfg_link_endpoint_if.sv
// Config-link bus seen by one tile endpoint: cfg request/response channel plus
// the single-outstanding forward port toward core/CCE.
interface bp_cfg_link_endpoint_if #(parameter int data_width_p = 64);
  logic                    cfg_v_i;
  logic                    cfg_ready_o;
  logic                    cfg_w_i;
  logic [31:0]             cfg_addr_i;
  logic [data_width_p-1:0] cfg_data_i;
  logic                    cfg_v_o;
  logic                    cfg_yumi_i;
  logic [data_width_p-1:0] cfg_data_o;
  logic                    cfg_err_o;
  logic                    fwd_v_o;
  logic                    fwd_ready_i;
  logic                    fwd_w_o;
  logic [1:0]              fwd_sel_o;
  logic [11:0]             fwd_idx_o;
  logic [data_width_p-1:0] fwd_data_o;
  logic                    fwd_resp_v_i;
  logic [data_width_p-1:0] fwd_resp_data_i;

  modport slave (
    input  cfg_v_i, cfg_w_i, cfg_addr_i, cfg_data_i, cfg_yumi_i,
           fwd_ready_i, fwd_resp_v_i, fwd_resp_data_i,
    output cfg_ready_o, cfg_v_o, cfg_data_o, cfg_err_o,
           fwd_v_o, fwd_w_o, fwd_sel_o, fwd_idx_o, fwd_data_o
  );

  modport master (
    output cfg_v_i, cfg_w_i, cfg_addr_i, cfg_data_i, cfg_yumi_i,
           fwd_ready_i, fwd_resp_v_i, fwd_resp_data_i,
    input  cfg_ready_o, cfg_v_o, cfg_data_o, cfg_err_o,
           fwd_v_o, fwd_w_o, fwd_sel_o, fwd_idx_o, fwd_data_o
  );
endinterface

// File: rtl/bp_cfg_link_endpoint.sv
// Tile config-link slave: local config registers plus forwarding of the
// IRF/FRF/CSR/ucode windows with a bounded wait for the forward response.
module bp_cfg_link_endpoint #(
  parameter logic [31:0] cfg_base_addr_p = 32'h0100_0000,
  parameter int          data_width_p    = 64,
  parameter int          core_id_width_p = 8,
  parameter int          did_width_p     = 3,
  parameter int          cord_width_p    = 8,
  parameter int          ucode_els_p     = 256,
  parameter logic [63:0] npc_reset_p     = 64'h8000_0000,
  parameter int          fwd_timeout_p   = 255
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  bp_cfg_link_endpoint_if.slave      bus,
  output logic                       soft_reset_o,
  output logic                       freeze_o,
  output logic [core_id_width_p-1:0] core_id_o,
  output logic [did_width_p-1:0]     did_o,
  output logic [did_width_p-1:0]     host_did_o,
  output logic [cord_width_p-1:0]    cord_o,
  output logic [1:0]                 icache_mode_o,
  output logic [1:0]                 dcache_mode_o,
  output logic [1:0]                 cce_mode_o,
  output logic [63:0]                npc_o,
  output logic [1:0]                 priv_o
);
  typedef logic [data_width_p-1:0] data_t;
  typedef enum logic [1:0] {IDLE, FWD_REQ, FWD_WAIT, RESP} state_e;

  state_e      state, state_n;
  logic [15:0] off;
  logic        base_ok, loc_hit, fwd_hit, gated, dec_err, accept, timeout;
  logic [1:0]  dec_sel;
  logic [11:0] dec_idx;
  data_t       loc_rdata;

  logic        req_w;
  logic [1:0]  req_sel;
  logic [11:0] req_idx;
  data_t       req_data;
  logic [9:0]  wait_cnt;
  data_t       resp_data;
  logic        resp_err;

  assign off     = bus.cfg_addr_i[15:0];
  assign base_ok = bus.cfg_addr_i[31:16] == cfg_base_addr_p[31:16];
  assign accept  = (state == IDLE) && bus.cfg_v_i;
  assign timeout = wait_cnt == 10'(fwd_timeout_p - 1);

  assign bus.cfg_ready_o = state == IDLE;
  assign bus.cfg_v_o     = state == RESP;
  assign bus.cfg_data_o  = resp_data;
  assign bus.cfg_err_o   = resp_err;
  assign bus.fwd_v_o     = state == FWD_REQ;
  assign bus.fwd_w_o     = req_w;
  assign bus.fwd_sel_o   = req_sel;
  assign bus.fwd_idx_o   = req_idx;
  assign bus.fwd_data_o  = req_data;

  // Address decode; 'gated' marks targets whose writes need the tile frozen.
  always_comb begin
    loc_hit   = 1'b1;
    gated     = 1'b0;
    loc_rdata = '0;
    fwd_hit   = 1'b0;
    dec_sel   = 2'd0;
    dec_idx   = '0;
    case (off)
      16'h0001: loc_rdata = data_t'(soft_reset_o);
      16'h0002: loc_rdata = data_t'(freeze_o);
      16'h0005: loc_rdata = data_t'(core_id_o);
      16'h0006: loc_rdata = data_t'(did_o);
      16'h0007: loc_rdata = data_t'(cord_o);
      16'h0008: loc_rdata = data_t'(host_did_o);
      16'h0022: loc_rdata = data_t'(icache_mode_o);
      16'h0040: begin loc_rdata = data_t'(npc_o);  gated = 1'b1; end
      16'h0043: loc_rdata = data_t'(dcache_mode_o);
      16'h0044: begin loc_rdata = data_t'(priv_o); gated = 1'b1; end
      16'h0081: loc_rdata = data_t'(cce_mode_o);
      default:  loc_hit = 1'b0;
    endcase
    if (off >= 16'h0050 && off <= 16'h006f) begin
      fwd_hit = 1'b1; dec_sel = 2'd0; dec_idx = 12'(off - 16'h0050); gated = 1'b1;
    end else if (off >= 16'h00a0 && off <= 16'h00bf) begin
      fwd_hit = 1'b1; dec_sel = 2'd1; dec_idx = 12'(off - 16'h00a0); gated = 1'b1;
    end else if (off[15:12] == 4'h6) begin
      fwd_hit = 1'b1; dec_sel = 2'd2; dec_idx = off[11:0]; gated = 1'b1;
    end else if ({1'b0, off} >= 17'h0_8000 && {1'b0, off} < 17'(32'h8000 + ucode_els_p)) begin
      fwd_hit = 1'b1; dec_sel = 2'd3; dec_idx = 12'(off - 16'h8000);
    end
    dec_err = !base_ok || !(loc_hit || fwd_hit) || (bus.cfg_w_i && !freeze_o && gated);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= IDLE;
    else            state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (accept) state_n = (dec_err || !fwd_hit) ? RESP : FWD_REQ;
      FWD_REQ:  if (bus.fwd_ready_i) state_n = FWD_WAIT;
      FWD_WAIT: if (bus.fwd_resp_v_i || timeout) state_n = RESP;
      RESP:     if (bus.cfg_yumi_i) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Request capture, wait counter and response registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      req_w     <= 1'b0;
      req_sel   <= 2'd0;
      req_idx   <= '0;
      req_data  <= '0;
      wait_cnt  <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_w    <= bus.cfg_w_i;
          req_sel  <= dec_sel;
          req_idx  <= dec_idx;
          req_data <= bus.cfg_data_i;
          if (dec_err) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else if (loc_hit) begin
            resp_data <= bus.cfg_w_i ? '0 : loc_rdata;
            resp_err  <= 1'b0;
          end
        end
        FWD_REQ: if (bus.fwd_ready_i) wait_cnt <= '0;
        FWD_WAIT: begin
          wait_cnt <= wait_cnt + 10'd1;
          // A response landing on the timeout cycle still counts as success.
          if (bus.fwd_resp_v_i) begin
            resp_data <= req_w ? '0 : bus.fwd_resp_data_i;
            resp_err  <= 1'b0;
          end else if (timeout) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end
        end
        RESP: if (bus.cfg_yumi_i) begin
          resp_data <= '0;
          resp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      soft_reset_o  <= 1'b1;
      freeze_o      <= 1'b1;
      core_id_o     <= '0;
      did_o         <= '0;
      host_did_o    <= '0;
      cord_o        <= '0;
      icache_mode_o <= '0;
      dcache_mode_o <= '0;
      cce_mode_o    <= '0;
      npc_o         <= npc_reset_p;
      priv_o        <= 2'd3;
    end else if (accept && !dec_err && loc_hit && bus.cfg_w_i) begin
      case (off)
        16'h0001: soft_reset_o  <= bus.cfg_data_i[0];
        16'h0002: freeze_o      <= bus.cfg_data_i[0];
        16'h0005: core_id_o     <= bus.cfg_data_i[core_id_width_p-1:0];
        16'h0006: did_o         <= bus.cfg_data_i[did_width_p-1:0];
        16'h0007: cord_o        <= bus.cfg_data_i[cord_width_p-1:0];
        16'h0008: host_did_o    <= bus.cfg_data_i[did_width_p-1:0];
        16'h0022: icache_mode_o <= bus.cfg_data_i[1:0];
        16'h0040: npc_o         <= 64'(bus.cfg_data_i);
        16'h0043: dcache_mode_o <= bus.cfg_data_i[1:0];
        16'h0044: priv_o        <= bus.cfg_data_i[1:0];
        16'h0081: cce_mode_o    <= bus.cfg_data_i[1:0];
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_cfg_link_endpoint.sv
// Directed bench for bp_cfg_link_endpoint: vector table for local registers,
// hand sequences for forwarding, freeze gating, timeout and mid-flight reset.
module tb_bp_cfg_link_endpoint;
  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        soft_reset_o, freeze_o;
  logic [7:0]  core_id_o, cord_o;
  logic [2:0]  did_o, host_did_o;
  logic [1:0]  icache_mode_o, dcache_mode_o, cce_mode_o, priv_o;
  logic [63:0] npc_o;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk_i = ~clk_i;

  bp_cfg_link_endpoint_if #(.data_width_p(64)) bus();

  bp_cfg_link_endpoint dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .bus(bus),
    .soft_reset_o(soft_reset_o), .freeze_o(freeze_o), .core_id_o(core_id_o),
    .did_o(did_o), .host_did_o(host_did_o), .cord_o(cord_o),
    .icache_mode_o(icache_mode_o), .dcache_mode_o(dcache_mode_o),
    .cce_mode_o(cce_mode_o), .npc_o(npc_o), .priv_o(priv_o)
  );

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts and ends on a negedge; on return the endpoint is one cycle past accept.
  task automatic send(input logic w, input logic [31:0] a, input logic [63:0] d);
    bus.cfg_v_i = 1'b1; bus.cfg_w_i = w; bus.cfg_addr_i = a; bus.cfg_data_i = d;
    @(posedge clk_i); #1;
    bus.cfg_v_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic take();
    bus.cfg_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    bus.cfg_yumi_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic xact(input string name, input logic w, input logic [31:0] a,
                      input logic [63:0] d, input logic [63:0] ed, input logic ee);
    send(w, a, d);
    chk({name, "_v"}, 64'(bus.cfg_v_o), 64'd1);
    chk({name, "_data"}, bus.cfg_data_o, ed);
    chk({name, "_err"}, 64'(bus.cfg_err_o), 64'(ee));
    take();
  endtask

  task automatic fwd_grant();
    bus.fwd_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.fwd_ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic fwd_respond(input logic [63:0] d);
    bus.fwd_resp_v_i = 1'b1; bus.fwd_resp_data_i = d;
    @(posedge clk_i); #1;
    bus.fwd_resp_v_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    int waited;
    bus.cfg_v_i = 0; bus.cfg_w_i = 0; bus.cfg_addr_i = '0; bus.cfg_data_i = '0;
    bus.cfg_yumi_i = 0; bus.fwd_ready_i = 0; bus.fwd_resp_v_i = 0; bus.fwd_resp_data_i = '0;

    tbl.push_back('{1'b0, 32'h0100_0040, 64'h0, 64'h8000_0000, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0002, 64'h0, 64'h1, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0001, 64'h0, 64'h1, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0044, 64'h0, 64'h3, 1'b0});
    tbl.push_back('{1'b1, 32'h0100_0006, 64'hF, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0006, 64'h0, 64'h7, 1'b0});
    tbl.push_back('{1'b1, 32'h0100_0007, 64'h13C, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0007, 64'h0, 64'h3C, 1'b0});
    tbl.push_back('{1'b1, 32'h0100_0008, 64'h5, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0008, 64'h0, 64'h5, 1'b0});
    tbl.push_back('{1'b1, 32'h0100_0022, 64'h6, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0022, 64'h0, 64'h2, 1'b0});
    tbl.push_back('{1'b1, 32'h0100_0043, 64'h1, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0043, 64'h0, 64'h1, 1'b0});
    tbl.push_back('{1'b1, 32'h0100_0081, 64'h3, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0081, 64'h0, 64'h3, 1'b0});
    tbl.push_back('{1'b1, 32'h0100_0040, 64'h1234_5678_9abc_def0, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0040, 64'h0, 64'h1234_5678_9abc_def0, 1'b0});
    tbl.push_back('{1'b1, 32'h0100_0044, 64'h1, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0044, 64'h0, 64'h1, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0003, 64'h0, 64'h0, 1'b1});
    tbl.push_back('{1'b0, 32'h0200_0001, 64'h0, 64'h0, 1'b1});
    tbl.push_back('{1'b1, 32'h0100_0000, 64'h55, 64'h0, 1'b1});
    tbl.push_back('{1'b1, 32'h0100_0001, 64'h0, 64'h0, 1'b0});
    tbl.push_back('{1'b0, 32'h0100_0001, 64'h0, 64'h0, 1'b0});

    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    chk("rst_cfg_v", 64'(bus.cfg_v_o), 64'd0);
    chk("rst_ready", 64'(bus.cfg_ready_o), 64'd1);
    chk("rst_fwd_v", 64'(bus.fwd_v_o), 64'd0);
    chk("rst_err", 64'(bus.cfg_err_o), 64'd0);
    chk("rst_data", bus.cfg_data_o, 64'd0);
    chk("rst_soft_reset", 64'(soft_reset_o), 64'd1);
    chk("rst_freeze", 64'(freeze_o), 64'd1);
    chk("rst_npc", npc_o, 64'h8000_0000);
    chk("rst_priv", 64'(priv_o), 64'd3);
    chk("rst_core_id", 64'(core_id_o), 64'd0);

    foreach (tbl[i]) xact($sformatf("vec%0d", i), tbl[i].w, tbl[i].addr, tbl[i].data,
                          tbl[i].exp_data, tbl[i].exp_err);

    // core_id write, response held until yumi
    send(1'b1, 32'h0100_0005, 64'h1A5);
    chk("core_id_upd", 64'(core_id_o), 64'hA5);
    for (int k = 0; k < 3; k++) begin
      chk("hold_v", 64'(bus.cfg_v_o), 64'd1);
      chk("hold_ready", 64'(bus.cfg_ready_o), 64'd0);
      @(negedge clk_i);
    end
    take();
    chk("after_yumi_v", 64'(bus.cfg_v_o), 64'd0);
    xact("core_id_rd", 1'b0, 32'h0100_0005, 64'h0, 64'hA5, 1'b0);

    // IRF read with backpressured forward port
    send(1'b0, 32'h0100_0055, 64'h0);
    for (int k = 0; k < 4; k++) begin
      chk("irf_fwd_v", 64'(bus.fwd_v_o), 64'd1);
      chk("irf_sel", 64'(bus.fwd_sel_o), 64'd0);
      chk("irf_idx", 64'(bus.fwd_idx_o), 64'd5);
      chk("irf_w", 64'(bus.fwd_w_o), 64'd0);
      @(negedge clk_i);
    end
    fwd_grant();
    chk("irf_wait_fwd_v", 64'(bus.fwd_v_o), 64'd0);
    chk("irf_wait_cfg_v", 64'(bus.cfg_v_o), 64'd0);
    fwd_respond(64'hDEAD);
    chk("irf_resp_v", 64'(bus.cfg_v_o), 64'd1);
    chk("irf_resp_data", bus.cfg_data_o, 64'hDEAD);
    chk("irf_resp_err", 64'(bus.cfg_err_o), 64'd0);
    take();

    // FRF write while frozen: forwarded, write response carries no data
    send(1'b1, 32'h0100_00a3, 64'h77);
    chk("frf_sel", 64'(bus.fwd_sel_o), 64'd1);
    chk("frf_idx", 64'(bus.fwd_idx_o), 64'd3);
    chk("frf_w", 64'(bus.fwd_w_o), 64'd1);
    chk("frf_data", bus.fwd_data_o, 64'h77);
    fwd_grant();
    fwd_respond(64'hFFFF);
    chk("frf_resp_data", bus.cfg_data_o, 64'd0);
    chk("frf_resp_err", 64'(bus.cfg_err_o), 64'd0);
    take();

    // Unfreeze, then gated writes must fail without side effects
    xact("unfreeze", 1'b1, 32'h0100_0002, 64'h0, 64'h0, 1'b0);
    chk("freeze_cleared", 64'(freeze_o), 64'd0);
    xact("npc_gated", 1'b1, 32'h0100_0040, 64'h1234, 64'h0, 1'b1);
    chk("npc_unchanged", npc_o, 64'h1234_5678_9abc_def0);
    send(1'b1, 32'h0100_0050, 64'h9);
    chk("irf_gated_fwd_v", 64'(bus.fwd_v_o), 64'd0);
    chk("irf_gated_err", 64'(bus.cfg_err_o), 64'd1);
    take();
    chk("irf_gated_fwd_v2", 64'(bus.fwd_v_o), 64'd0);

    // ucode writes are not freeze-gated
    send(1'b1, 32'h0100_8001, 64'h55);
    chk("uc_fwd_v", 64'(bus.fwd_v_o), 64'd1);
    chk("uc_sel", 64'(bus.fwd_sel_o), 64'd3);
    chk("uc_idx", 64'(bus.fwd_idx_o), 64'd1);
    fwd_grant();
    fwd_respond(64'h0);
    chk("uc_resp_err", 64'(bus.cfg_err_o), 64'd0);
    take();

    // CSR read that never gets answered
    send(1'b0, 32'h0100_6300, 64'h0);
    chk("csr_sel", 64'(bus.fwd_sel_o), 64'd2);
    chk("csr_idx", 64'(bus.fwd_idx_o), 64'h300);
    bus.fwd_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.fwd_ready_i = 1'b0;
    @(negedge clk_i);
    waited = 0;
    while (bus.cfg_v_o !== 1'b1 && waited < 2000) begin
      waited++;
      @(negedge clk_i);
    end
    chk("timeout_cycles", 64'(waited), 64'd255);
    chk("timeout_err", 64'(bus.cfg_err_o), 64'd1);
    chk("timeout_data", bus.cfg_data_o, 64'd0);
    take();
    fwd_respond(64'hBAD);
    chk("late_resp_v", 64'(bus.cfg_v_o), 64'd0);
    chk("late_resp_ready", 64'(bus.cfg_ready_o), 64'd1);
    xact("after_late", 1'b0, 32'h0100_0005, 64'h0, 64'hA5, 1'b0);

    // Response on the same cycle the timeout would fire
    send(1'b0, 32'h0100_6301, 64'h0);
    bus.fwd_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.fwd_ready_i = 1'b0;
    repeat (255) @(negedge clk_i);
    chk("coinc_pre_v", 64'(bus.cfg_v_o), 64'd0);
    fwd_respond(64'hBEEF);
    chk("coinc_v", 64'(bus.cfg_v_o), 64'd1);
    chk("coinc_err", 64'(bus.cfg_err_o), 64'd0);
    chk("coinc_data", bus.cfg_data_o, 64'hBEEF);
    take();

    // Reset while waiting on a forward response
    send(1'b0, 32'h0100_6002, 64'h0);
    fwd_grant();
    reset_n_i = 1'b0;
    #1;
    chk("mid_rst_cfg_v", 64'(bus.cfg_v_o), 64'd0);
    chk("mid_rst_freeze", 64'(freeze_o), 64'd1);
    chk("mid_rst_ready", 64'(bus.cfg_ready_o), 64'd1);
    chk("mid_rst_fwd_v", 64'(bus.fwd_v_o), 64'd0);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    fwd_respond(64'h1);
    repeat (2) @(negedge clk_i);
    chk("post_rst_cfg_v", 64'(bus.cfg_v_o), 64'd0);
    xact("post_rst_npc", 1'b0, 32'h0100_0040, 64'h0, 64'h8000_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bp_cfg_link_endpoint.md
Name: bp_cfg_link_endpoint

Overview:
- Config-link slave for one tile: decodes cfg-bus reads/writes into local tile config registers (reset, freeze, IDs, cache/CCE modes, npc, priv).
- Forwards the IRF, FRF, CSR and CCE-ucode windows to core/CCE over a one-outstanding request/response port.
- Generalises the fixed cfg map: parametrised base, widths and window sizes; 64-bit npc; error responses; freeze-gated writes; forward timeout.

Parameters:
- cfg_base_addr_p, 'h0100_0000, region base; addr[31:16] must equal cfg_base_addr_p[31:16].
- data_width_p, 64, cfg data width.
- core_id_width_p, 8, core_id register width.
- did_width_p, 3, did/host_did register width.
- cord_width_p, 8, cord register width.
- ucode_els_p, 256, ucode entries mapped at offset 'h8000.
- npc_reset_p, 'h8000_0000, npc reset value.
- fwd_timeout_p, 255, forward-wait timeout in cycles (max 1023).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  reset, asynchronous, active-low
- cfg_v_i  in  1  request valid
- cfg_ready_o  out  1  request ready
- cfg_w_i  in  1  1=write, 0=read
- cfg_addr_i  in  32  byte-agnostic register address
- cfg_data_i  in  data_width_p  write data
- cfg_v_o  out  1  response valid
- cfg_yumi_i  in  1  response consumed
- cfg_data_o  out  data_width_p  read data (0 for writes/errors)
- cfg_err_o  out  1  response error flag
- soft_reset_o  out  1  tile reset register
- freeze_o  out  1  freeze register
- core_id_o  out  core_id_width_p  core id
- did_o  out  did_width_p  domain id
- host_did_o  out  did_width_p  host domain id
- cord_o  out  cord_width_p  coordinate
- icache_mode_o, dcache_mode_o, cce_mode_o  out  2 each  mode registers
- npc_o  out  64  next PC
- priv_o  out  2  privilege
- fwd_v_o  out  1  forward request valid
- fwd_ready_i  in  1  forward request ready
- fwd_w_o  out  1  forward write
- fwd_sel_o  out  2  0=IRF, 1=FRF, 2=CSR, 3=ucode
- fwd_idx_o  out  12  index within window
- fwd_data_o  out  data_width_p  forward write data
- fwd_resp_v_i  in  1  forward response valid
- fwd_resp_data_i  in  data_width_p  forward read data

Behaviour:
- Reset (async assert, sync release): state IDLE; cfg_v_o=0, fwd_v_o=0, cfg_err_o=0, cfg_data_o=0; soft_reset_o=1, freeze_o=1, ids/cord/modes=0, npc_o=npc_reset_p, priv_o=3.
- Reset mid-transaction: drops all pending work; no response is issued.
- Offset map (off = addr[15:0]): 'h0001 reset; 'h0002 freeze; 'h0005 core_id; 'h0006 did; 'h0007 cord; 'h0008 host_did; 'h0022 icache_mode; 'h0040 npc; 'h0043 dcache_mode; 'h0044 priv; 'h0081 cce_mode.
- Forwarded windows: 'h0050-'h006f IRF (idx=off-'h50); 'h00a0-'h00bf FRF; 'h6000-'h6fff CSR (idx=off[11:0]); 'h8000..'h8000+ucode_els_p-1 ucode.
- Unmapped offset or base mismatch: error response.
- Write data takes low bits of cfg_data_i; reads zero-extend.
- FSM states: IDLE, FWD_REQ, FWD_WAIT, RESP.
- cfg_ready_o = (state==IDLE).
- Accept in IDLE when cfg_v_i & cfg_ready_o.
- Local register or error access: accepted cycle N; register updated and response in RESP at N+1.
- Forward access: FWD_REQ holds fwd_v_o and payload stable until fwd_ready_i, then FWD_WAIT.
- FWD_WAIT exit on fwd_resp_v_i: RESP, cfg_data_o = fwd_resp_data_i for reads, 0 for writes.
- Timeout counter: cleared on entry to FWD_WAIT. At fwd_timeout_p cycles without a response, go to RESP with err=1, data=0.
- Response and timeout in the same cycle: the response wins.
- fwd_resp_v_i outside FWD_WAIT: ignored.
- RESP: cfg_v_o=1, data/err stable until cfg_yumi_i, then IDLE.
- Next request accepted no earlier than the cycle after yumi.
- Freeze gating: writes to npc, priv, IRF, FRF or CSR while freeze_o=0 give err=1, no state change, no forward. Reads are always allowed.
- Write to 'h0002 with data bit0=0 unfreezes; gating applies from the next request.

Test Plan:
- Reset then read 'h0100_0040 -> response next cycle, data='h8000_0000, err=0; read 'h0100_0002 -> data=1.
- Write core_id 'h0100_0005 data 'h1A5 -> core_id_o='hA5 at N+1; read back 'hA5; response held 3 cycles until yumi.
- Read 'h0100_0055 with fwd_ready_i low 4 cycles -> fwd_v_o stable, sel=0, idx=5; response 'hDEAD -> cfg_data_o='hDEAD, err=0.
- Unfreeze (write 'h0100_0002 data 0), then write npc 'h1234 -> err=1 and npc unchanged; write IRF -> err=1, fwd_v_o never rises.
- Forward CSR read 'h0100_6300, no response -> err=1 after 255 wait cycles; late fwd_resp_v_i in IDLE ignored; response coincident with timeout -> err=0.
- Read 'h0100_0003 or 'h0200_0001 -> err=1, data=0; assert reset_n_i during FWD_WAIT -> cfg_v_o=0, freeze_o=1, state IDLE.
